// File: rtl/booth_mul32_if.sv
// Request/response bundle for the sequential radix-2 Booth multiplier.
// The master drives operands and start; the slave returns status, product and flags.
interface booth_mul32_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;
  logic                 OF;
  logic                 SF;
  logic                 ZF;

  modport master (
    output start, x, y,
    input  busy, done, p, OF, SF, ZF
  );

  modport slave (
    input  start, x, y,
    output busy, done, p, OF, SF, ZF
  );
endinterface

// File: rtl/booth_mul32.sv
// Signed WIDTH x WIDTH multiplier, one radix-2 Booth step per cycle.
// Fixed latency: done pulses WIDTH+1 cycles after the start-accept edge.
module booth_mul32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  booth_mul32_if.slave     bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state, state_nx;

  // A carries one extra bit so subtracting the most negative multiplicand cannot overflow.
  logic [WIDTH:0]       m;
  logic [WIDTH:0]       a;
  logic [WIDTH-1:0]     q;
  logic                 q_1;
  logic [CW-1:0]        count;

  logic [2*WIDTH-1:0]   p_q;
  logic                 of_q, sf_q, zf_q;

  logic                 last;
  logic [WIDTH:0]       a_sum;
  logic [WIDTH:0]       a_nx;
  logic [WIDTH-1:0]     q_nx;
  logic                 q1_nx;
  logic [2*WIDTH-1:0]   prod_nx;
  logic [WIDTH:0]       prod_hi;

  assign last = (count == CW'(WIDTH - 1));

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    a_sum = a;
    unique case ({q[0], q_1})
      2'b01:   a_sum = a + m;
      2'b10:   a_sum = a - m;
      default: a_sum = a;
    endcase
  end

  // Arithmetic right shift of {A,Q,q_1}; the old q_1 falls off the bottom.
  assign {a_nx, q_nx, q1_nx} = {a_sum[WIDTH], a_sum, q};
  assign prod_nx             = {a_nx[WIDTH-1:0], q_nx};
  assign prod_hi             = prod_nx[2*WIDTH-1:WIDTH-1];

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (bus.start) state_nx = CALC;
      CALC:    if (last)      state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m     <= '0;
      a     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
      p_q   <= '0;
      of_q  <= 1'b0;
      sf_q  <= 1'b0;
      zf_q  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            m     <= {bus.x[WIDTH-1], bus.x};
            a     <= '0;
            q     <= bus.y;
            q_1   <= 1'b0;
            count <= '0;
          end
        end
        CALC: begin
          a   <= a_nx;
          q   <= q_nx;
          q_1 <= q1_nx;
          if (last) begin
            p_q  <= prod_nx;
            sf_q <= prod_nx[2*WIDTH-1];
            zf_q <= (prod_nx == '0);
            of_q <= ~((prod_hi == '0) || (prod_hi == '1));
          end else begin
            count <= count + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state != IDLE);
  assign bus.done = (state == DONE);
  assign bus.p    = p_q;
  assign bus.OF   = of_q;
  assign bus.SF   = sf_q;
  assign bus.ZF   = zf_q;

endmodule

// File: tb/tb_booth_mul32.sv
// Directed and random checks of booth_mul32 against a queued reference of expected results.
module tb_booth_mul32;

  typedef struct {
    logic [63:0] p;
    logic        of;
    logic        sf;
    logic        zf;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   passed = 0;
  int   total  = 0;
  exp_t sb[$];

  booth_mul32_if #(.WIDTH(32)) bif ();

  booth_mul32 #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic exp_t model(input logic [31:0] xv, input logic [31:0] yv);
    exp_t   e;
    longint pr;
    pr   = longint'($signed(xv)) * longint'($signed(yv));
    e.p  = pr;
    e.sf = e.p[63];
    e.zf = (e.p == 64'd0);
    e.of = !((e.p[63:31] == 33'd0) || (e.p[63:31] == {33{1'b1}}));
    return e;
  endfunction

  // Drive start for one edge in IDLE; afterwards the bench sits in the first CALC cycle.
  task automatic do_start(input logic [31:0] xv, input logic [31:0] yv, input exp_t e);
    bif.x     = xv;
    bif.y     = yv;
    bif.start = 1'b1;
    sb.push_back(e);
    tick();
    bif.start = 1'b0;
    bif.x     = $urandom;
    bif.y     = $urandom;
  endtask

  // elapsed: CALC cycles already spent since the accept edge (done expected after 32 total).
  task automatic wait_result(input string tag, input int elapsed);
    int   n;
    exp_t e;
    n = elapsed;
    while (!bif.done && n < 40) begin
      tick();
      n++;
    end
    check({tag, " latency"}, 64'(n), 64'd32);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, " p"},  bif.p,        e.p);
      check({tag, " OF"}, 64'(bif.OF),  64'(e.of));
      check({tag, " SF"}, 64'(bif.SF),  64'(e.sf));
      check({tag, " ZF"}, 64'(bif.ZF),  64'(e.zf));
    end
    tick();
    check({tag, " done drop"}, 64'(bif.done), 64'd0);
  endtask

  initial begin
    exp_t        e;
    logic [63:0] held;
    int          seen_done;
    logic [31:0] rx, ry;

    rst       = 1'b1;
    bif.start = 1'b0;
    bif.x     = '0;
    bif.y     = '0;
    tick();
    tick();
    rst = 1'b0;
    check("rst busy", 64'(bif.busy), 64'd0);
    check("rst done", 64'(bif.done), 64'd0);
    check("rst p",    bif.p,         64'd0);
    check("rst OF",   64'(bif.OF),   64'd0);
    check("rst SF",   64'(bif.SF),   64'd0);
    check("rst ZF",   64'(bif.ZF),   64'd0);

    // Idle with start low: nothing moves.
    tick();
    tick();
    check("idle busy", 64'(bif.busy), 64'd0);

    e = '{p: 64'hC00000017FFFFFFE, of: 1'b1, sf: 1'b1, zf: 1'b0};
    do_start(32'h7FFFFFFF, 32'h80000002, e);
    check("max*neg busy", 64'(bif.busy), 64'd1);
    wait_result("max*neg", 0);

    e = '{p: 64'hFFFFFFFFFFFFFFFF, of: 1'b0, sf: 1'b1, zf: 1'b0};
    do_start(32'hFFFFFFFF, 32'h00000001, e);
    wait_result("m1*1", 0);

    e = '{p: 64'h4000000000000000, of: 1'b1, sf: 1'b0, zf: 1'b0};
    do_start(32'h80000000, 32'h80000000, e);
    wait_result("min*min", 0);

    // Reset at CALC cycle 10 aborts the multiply with no done pulse.
    do_start(32'd3, 32'd5, model(32'd3, 32'd5));
    for (int i = 1; i < 10; i++) tick();
    check("abort p held", bif.p, 64'h4000000000000000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    void'(sb.pop_back());
    check("abort busy", 64'(bif.busy), 64'd0);
    check("abort p",    bif.p,         64'd0);
    check("abort OF",   64'(bif.OF),   64'd0);
    check("abort ZF",   64'(bif.ZF),   64'd0);
    seen_done = 0;
    for (int i = 0; i < 30; i++) begin
      if (bif.done) seen_done++;
      tick();
    end
    check("abort no done", 64'(seen_done), 64'd0);
    do_start(32'd3, 32'd5, model(32'd3, 32'd5));
    wait_result("3*5 after abort", 0);

    // Zero product, then a mid-CALC start with new operands that must be ignored.
    e = '{p: 64'd0, of: 1'b0, sf: 1'b0, zf: 1'b1};
    do_start(32'h00000000, 32'h12345678, e);
    held = bif.p;
    for (int i = 1; i < 16; i++) tick();
    check("calc p stable", bif.p, held);
    bif.x     = 32'd5;
    bif.y     = 32'd7;
    bif.start = 1'b1;
    tick();
    bif.start = 1'b0;
    wait_result("zero", 16);
    tick();
    check("ignored start idle", 64'(bif.busy), 64'd0);

    for (int k = 0; k < 1000; k++) begin
      rx = $urandom;
      ry = $urandom;
      do_start(rx, ry, model(rx, ry));
      wait_result($sformatf("rand%0d", k), 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/booth_mul32.md
BOOTH_MUL32 -- requirements
Module: booth_mul32

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; all widths below are stated for WIDTH=32.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge only.
REQ-003 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port x, input, 32 bits: multiplicand, two's complement.
REQ-006 The block SHALL have port y, input, 32 bits: multiplier, two's complement.
REQ-007 The block SHALL have port busy, output, 1 bit: high while in CALC or DONE.
REQ-008 The block SHALL have port done, output, 1 bit: single-cycle pulse, high while in DONE.
REQ-009 The block SHALL have port p, output, 64 bits: signed product x*y.
REQ-010 The block SHALL have port OF, output, 1 bit: high when the product does not fit in signed 32 bits.
REQ-011 The block SHALL have port SF, output, 1 bit: equal to p[63].
REQ-012 The block SHALL have port ZF, output, 1 bit: high when p==0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 In IDLE with start=1, the block SHALL on that edge latch M=sign-extend(x) to 33 bits, Q=y, q_1=0, A=0 and count=0, then go to CALC.
REQ-015 In IDLE with start=0, the block SHALL keep all state, including p and the flags.
REQ-016 In CALC, each cycle SHALL inspect {Q[0],q_1}: 01 -> A=A+M; 10 -> A=A-M; 00 or 11 -> A unchanged.
REQ-017 In CALC, each cycle SHALL then shift the 66-bit vector {A,Q,q_1} arithmetically right by one bit, with A[32] replicated.
REQ-018 A SHALL be 33 bits wide so that x=0x80000000 (where -M needs 33 bits) cannot overflow.
REQ-019 CALC SHALL last exactly WIDTH cycles (count 0..31); after the final iteration the FSM SHALL go to DONE.
REQ-020 On the CALC->DONE edge, the block SHALL register p={A[31:0],Q}, SF=p[63], ZF=(p==0) and OF=~(p[63:31] all-zero or all-one).
REQ-021 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-022 Latency SHALL be fixed: done is high in the 33rd cycle after the start-accept edge, whatever the operand values.
REQ-023 start SHALL be ignored in CALC and DONE; x and y MAY change after the accept edge without affecting the result.
REQ-024 A start asserted in the IDLE cycle after DONE SHALL be accepted, giving back-to-back throughput of one result per 34 cycles.
REQ-025 p and the flags SHALL hold the last result until the next CALC->DONE edge; they SHALL NOT change during CALC.
REQ-026 Reaching count=WIDTH-1 SHALL NOT wrap into a further iteration.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL enter IDLE and clear busy, done, p, OF, SF, ZF, A, Q, q_1 and count to 0.
REQ-028 rst SHALL take priority over start and over every FSM transition.
REQ-029 A reset during CALC or DONE SHALL abort the operation with no done pulse.
REQ-030 After reset, ZF SHALL read 0 (register reset value), not a value computed from p.

Verification
REQ-031 The bench SHALL apply x=0x7FFFFFFF, y=0x80000002, start -> done in the 33rd cycle after accept, p=0xC00000017FFFFFFE, OF=1, SF=1, ZF=0.
REQ-032 The bench SHALL apply x=0xFFFFFFFF, y=0x00000001 -> p=0xFFFFFFFFFFFFFFFF, OF=0, SF=1, ZF=0.
REQ-033 The bench SHALL apply x=0x80000000, y=0x80000000 -> p=0x4000000000000000, OF=1, SF=0, ZF=0.
REQ-034 The bench SHALL apply x=0x00000000, y=0x12345678 -> p=0, ZF=1, OF=0, SF=0; then pulse start at mid-CALC with new operands -> ignored, result unchanged.
REQ-035 The bench SHALL start x=3, y=5, assert rst at cycle 10 of CALC -> next cycle busy=0, p=0, and no done pulse; a following start then gives p=15 on time.
REQ-036 The bench SHALL apply 1000 $random operand pairs back-to-back, start issued in the cycle after each done -> p equals the 64-bit signed reference product and the flags match REQ-020.
